// File: rtl/reference_reader.sv
// reference_reader: issues wrapping index runs to the reference buffer and streams returned I/Q samples out
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   start, offset, length           run request (sampled in IDLE only)
//   s_axis_index_tvalid/tdata/tready index request stream toward the buffer
//   m_axis_data_tvalid/i/q          returned samples (cannot be stalled)
//   out_tvalid/i/q/tlast/tready     backpressured sample stream toward the correlator
//   busy, done, err                 run status
module reference_reader #(
   parameter int buffer_length = 10,
   parameter int index_bits    = 4,
   parameter int i_bits        = 12,
   parameter int q_bits        = 12,
   parameter int fifo_depth    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [index_bits-1:0] offset,
   input  logic [index_bits:0]   length,
   output logic                  s_axis_index_tvalid,
   output logic [index_bits-1:0] s_axis_index_tdata,
   input  logic                  s_axis_index_tready,
   input  logic                  m_axis_data_tvalid,
   input  logic [i_bits-1:0]     m_axis_data_i,
   input  logic [q_bits-1:0]     m_axis_data_q,
   output logic                  out_tvalid,
   output logic [i_bits-1:0]     out_i,
   output logic [q_bits-1:0]     out_q,
   output logic                  out_tlast,
   input  logic                  out_tready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int PW = $clog2(fifo_depth);
   localparam int CW = PW + 1;
   localparam int LW = index_bits + 1;
   localparam logic [CW:0]           DEPTH    = (CW+1)'(fifo_depth);
   localparam logic [LW-1:0]         BLEN     = LW'(buffer_length);
   localparam logic [index_bits-1:0] LAST_IDX = index_bits'(buffer_length - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t                state;
   logic [index_bits-1:0] index;
   logic [LW-1:0]         issued, len_r, ret_cnt;
   logic [CW-1:0]         outstanding, count;
   logic [PW-1:0]         wptr, rptr;
   logic [i_bits-1:0]     mem_i [fifo_depth];
   logic [q_bits-1:0]     mem_q [fifo_depth];
   logic [fifo_depth-1:0] mem_l;
   logic [CW:0]           credit_sum;
   logic                  hs, push, pop, bad;
   // requests in flight plus samples held never exceed the FIFO depth, so a return always has a slot
   assign credit_sum          = {1'b0, outstanding} + {1'b0, count};
   assign s_axis_index_tvalid = state == ISSUE && credit_sum < DEPTH;
   assign s_axis_index_tdata  = index;
   assign hs                  = s_axis_index_tvalid & s_axis_index_tready;
   assign push                = m_axis_data_tvalid && state != IDLE;
   assign out_tvalid          = count != '0;
   assign pop                 = out_tvalid & out_tready;
   assign out_i               = mem_i[rptr];
   assign out_q               = mem_q[rptr];
   assign out_tlast           = out_tvalid & mem_l[rptr];
   assign bad                 = {1'b0, offset} >= BLEN || length > BLEN;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         index       <= '0;
         issued      <= '0;
         len_r       <= '0;
         ret_cnt     <= '0;
         outstanding <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done        <= 1'b0;
         err         <= 1'b0;
         outstanding <= outstanding + CW'(hs) - CW'(push);
         if (push) ret_cnt <= ret_cnt + LW'(1);
         case (state)
            IDLE: if (start) begin
               if (bad) begin
                  done <= 1'b1;
                  err  <= 1'b1;
               end else if (length == '0) begin
                  done <= 1'b1;
               end else begin
                  index   <= offset;
                  len_r   <= length;
                  issued  <= '0;
                  ret_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: if (hs) begin
               index  <= index == LAST_IDX ? '0 : index + index_bits'(1);
               issued <= issued + LW'(1);
               if (issued + LW'(1) == len_r) state <= DRAIN;
            end
            DRAIN: if (outstanding == '0 && count == '0) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         mem_l <= '0;
         for (int k = 0; k < fifo_depth; k++) begin
            mem_i[k] <= '0;
            mem_q[k] <= '0;
         end
      end else begin
         if (push) begin
            mem_i[wptr] <= m_axis_data_i;
            mem_q[wptr] <= m_axis_data_q;
            // tag the entry carrying sample number length of the run
            mem_l[wptr] <= (ret_cnt + LW'(1)) == len_r;
            wptr        <= wptr + PW'(1);
         end
         if (pop) rptr <= rptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_reference_reader.sv
// tb_reference_reader: randomized and directed runs against a buffer model and a sequence-level reference
module tb_reference_reader;
   localparam int BL = 10;
   localparam int IB = 4;
   localparam int IW = 12;
   localparam int QW = 12;
   localparam int FD = 4;
   logic          clk = 0;
   logic          rst = 0;
   logic          start = 0;
   logic [IB-1:0] offset = 0;
   logic [IB:0]   length = 0;
   logic          idx_valid;
   logic [IB-1:0] idx_data;
   logic          idx_ready = 1;
   logic          dv = 0;
   logic [IW-1:0] di = 0;
   logic [QW-1:0] dq = 0;
   logic          ov;
   logic [IW-1:0] oi;
   logic [QW-1:0] oq;
   logic          olast;
   logic          ordy = 1;
   logic          busy, done, err;
   int            checks = 0;
   int            failures = 0;
   logic [23:0]   rom [BL];
   logic          p1_v = 0;
   logic [IB-1:0] p1_idx = 0;

   reference_reader #(.buffer_length(BL), .index_bits(IB), .i_bits(IW), .q_bits(QW), .fifo_depth(FD)) dut (
      .clk(clk), .rst(rst), .start(start), .offset(offset), .length(length),
      .s_axis_index_tvalid(idx_valid), .s_axis_index_tdata(idx_data), .s_axis_index_tready(idx_ready),
      .m_axis_data_tvalid(dv), .m_axis_data_i(di), .m_axis_data_q(dq),
      .out_tvalid(ov), .out_i(oi), .out_q(oq), .out_tlast(olast), .out_tready(ordy),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // reference buffer: fixed 2-cycle latency, never reset, never stalled
   always @(posedge clk) begin
      p1_v     <= idx_valid & idx_ready;
      p1_idx   <= idx_data;
      dv       <= p1_v;
      {di, dq} <= p1_v ? rom[p1_idx] : 24'h0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_zero(input string tag);
      chk({tag, "_ivalid"}, 32'(idx_valid), 0);
      chk({tag, "_ovalid"}, 32'(ov), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
   endtask

   task automatic run(input int off, input int len, input int stall, input bit tog, input bit inject);
      int       n_idx = 0;
      int       n_out = 0;
      int       last_pop = -10;
      int       done_cyc = -1;
      bit       prev_stall = 0;
      logic [IB-1:0] prev_data = 0;
      @(negedge clk);
      start = 1; offset = IB'(off); length = (IB+1)'(len); ordy = stall == 0; idx_ready = 1;
      @(negedge clk);
      start = 0;
      for (int c = 0; c < 600 && done_cyc < 0; c++) begin
         ordy = c >= stall;
         idx_ready = tog ? (c % 2 == 0) : 1'b1;
         if (inject && c == 5) begin
            start = 1; offset = 7; length = 3;
         end else start = 0;
         if (c == 0) chk("busy_run", 32'(busy), 1);
         if (stall > 0 && c == stall) chk("stall_idx", 32'(n_idx), 32'(len < FD ? len : FD));
         if (prev_stall) begin
            chk("hold_valid", 32'(idx_valid), 1);
            chk("hold_data", 32'(idx_data), 32'(prev_data));
         end
         if (idx_valid && idx_ready) begin
            chk("index", 32'(idx_data), 32'((off + n_idx) % BL));
            n_idx++;
         end
         prev_stall = idx_valid && !idx_ready;
         prev_data = idx_data;
         if (ov && ordy) begin
            chk("out_iq", 32'({oi, oq}), 32'(rom[(off + n_out) % BL]));
            chk("out_last", 32'(olast), 32'(n_out == len - 1));
            n_out++;
            last_pop = c;
         end
         if (done) begin
            done_cyc = c;
            chk("done_err", 32'(err), 0);
            chk("done_busy", 32'(busy), 0);
            chk("done_time", 32'(c), 32'(last_pop + 2));
            chk("n_out", 32'(n_out), 32'(len));
            chk("n_idx", 32'(n_idx), 32'(len));
         end
         @(negedge clk);
      end
      start = 0;
      chk("run_done", 32'(done_cyc >= 0), 1);
      chk("done_pulse", 32'(done), 0);
   endtask

   task automatic bad_start(input int off, input int len, input bit exp_err);
      @(negedge clk);
      start = 1; offset = IB'(off); length = (IB+1)'(len);
      @(negedge clk);
      start = 0;
      chk("rej_done", 32'(done), 1);
      chk("rej_err", 32'(err), 32'(exp_err));
      chk("rej_ivalid", 32'(idx_valid), 0);
      @(negedge clk);
      idle_zero("rej_after");
   endtask

   initial begin
      int n;
      for (int k = 0; k < BL; k++) rom[k] = 24'($urandom);
      #1 rst = 1;
      #1;
      idle_zero("reset");
      chk("reset_oi", 32'(oi), 0);
      chk("reset_oq", 32'(oq), 0);
      chk("reset_last", 32'(olast), 0);
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (2) @(negedge clk);
      run(0, 10, 0, 0, 0);
      run(8, 5, 0, 0, 0);
      run(0, 10, 20, 0, 0);
      run(3, 10, 0, 1, 0);
      bad_start(12, 5, 1);
      bad_start(0, 11, 1);
      bad_start(3, 0, 0);
      run(5, 7, 0, 0, 1);
      repeat (3) @(negedge clk);
      idle_zero("ignored_start");
      repeat (6) run($urandom_range(0, BL - 1), $urandom_range(1, BL), $urandom_range(0, 1) * 12,
                     1'($urandom_range(0, 1)), 0);
      @(negedge clk);
      start = 1; offset = 0; length = 10; ordy = 1; idx_ready = 1;
      @(negedge clk);
      start = 0;
      n = 0;
      for (int c = 0; c < 50 && n < 3; c++) begin
         if (idx_valid && idx_ready) n++;
         @(negedge clk);
      end
      chk("rst_hs", 32'(n), 3);
      rst = 1;
      #1;
      idle_zero("midrun_rst");
      chk("midrun_oi", 32'(oi), 0);
      chk("midrun_oq", 32'(oq), 0);
      chk("midrun_last", 32'(olast), 0);
      #1 rst = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("late_ret_ovalid", 32'(ov), 0);
         chk("late_ret_busy", 32'(busy), 0);
      end
      run(0, 10, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
